// File: rtl/systolic_array_kv.sv
// systolic_array_kv: two-row systolic priority queue of key/payload pairs.
// Row B holds the sorted chain with B[0] at the head. Row A holds pending
// entries, each no better than the B slot of its own cell. Every accepted op
// is followed by one SETTLE cycle in which each cell does one local
// compare-exchange with its neighbours.
//
// state  | meaning
// -------+----------------------------------------------------------
// READY  | idle, invariant holds, one op may be accepted this cycle
// SETTLE | local compare-exchange pass, requests ignored
module systolic_array_kv #(
    parameter int QUEUE_SIZE = 8,
    parameter int KEY_WIDTH  = 16,
    parameter int VAL_WIDTH  = 16,
    parameter int MAX_MODE   = 0
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              i_wrt,
    input  logic                              i_read,
    input  logic                              i_flush,
    input  logic [KEY_WIDTH-1:0]              i_key,
    input  logic [VAL_WIDTH-1:0]              i_val,
    output logic                              o_ready,
    output logic                              o_full,
    output logic                              o_empty,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]   o_count,
    output logic                              o_valid,
    output logic [KEY_WIDTH-1:0]              o_key,
    output logic [VAL_WIDTH-1:0]              o_val,
    output logic                              o_drop
);

    localparam int N  = QUEUE_SIZE / 2;
    localparam int CW = $clog2(QUEUE_SIZE + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_SIZE);

    typedef enum logic {ST_READY, ST_SETTLE} state_t;

    state_t state_q, state_d;

    logic                 a_vld [N];
    logic [KEY_WIDTH-1:0] a_key [N];
    logic [VAL_WIDTH-1:0] a_val [N];
    logic                 b_vld [N];
    logic [KEY_WIDTH-1:0] b_key [N];
    logic [VAL_WIDTH-1:0] b_val [N];
    logic [CW-1:0]        count_q;
    logic                 drop_q;

    // B row extended by one always-invalid slot so cell N-1 has a right neighbour
    logic                 bx_vld [N+1];
    logic [KEY_WIDTH-1:0] bx_key [N+1];
    logic [VAL_WIDTH-1:0] bx_val [N+1];

    // pull: B[k] takes the better of A[k] and B[k+1] (the row after a pop)
    logic                 pa_vld [N];
    logic [KEY_WIDTH-1:0] pa_key [N];
    logic [VAL_WIDTH-1:0] pa_val [N];
    logic                 pb_vld [N];
    logic [KEY_WIDTH-1:0] pb_key [N];
    logic [VAL_WIDTH-1:0] pb_val [N];

    // insert: row A shifted right up to its first hole, new pair at A[0]
    logic                 sa_vld [N];
    logic [KEY_WIDTH-1:0] sa_key [N];
    logic [VAL_WIDTH-1:0] sa_val [N];
    logic                 ia_vld [N];
    logic [KEY_WIDTH-1:0] ia_key [N];
    logic [VAL_WIDTH-1:0] ia_val [N];

    // settle: result of the per-cell compare-exchange
    logic                 ta_vld [N];
    logic [KEY_WIDTH-1:0] ta_key [N];
    logic [VAL_WIDTH-1:0] ta_val [N];
    logic                 tb_vld [N];
    logic [KEY_WIDTH-1:0] tb_key [N];
    logic [VAL_WIDTH-1:0] tb_val [N];

    logic do_flush, do_enq, do_deq, do_rep, drop_d, full, empty;

    // Strict ordering; an invalid slot never wins and ties never win.
    function automatic logic better(input logic va, input logic [KEY_WIDTH-1:0] ka,
                                    input logic vb, input logic [KEY_WIDTH-1:0] kb);
        if (!va) return 1'b0;
        if (!vb) return 1'b1;
        if (MAX_MODE != 0) return ka > kb;
        return ka < kb;
    endfunction

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Op decode and next state; flush outranks everything, rejected ops raise drop.
    always_comb begin
        state_d  = state_q;
        do_flush = 1'b0;
        do_enq   = 1'b0;
        do_deq   = 1'b0;
        do_rep   = 1'b0;
        drop_d   = 1'b0;
        if (state_q == ST_SETTLE) begin
            state_d = ST_READY;
        end else begin
            if (i_flush) begin
                do_flush = 1'b1;
            end else if (i_wrt && i_read) begin
                do_rep = 1'b1;
            end else if (i_wrt) begin
                do_enq = !full;
                drop_d = full;
            end else if (i_read) begin
                do_deq = !empty;
                drop_d = empty;
            end
            if (do_flush || do_enq || do_deq || do_rep) state_d = ST_SETTLE;
        end
    end

    // Extended B row with an invalid sentinel cell past the end.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            bx_vld[k] = b_vld[k];
            bx_key[k] = b_key[k];
            bx_val[k] = b_val[k];
        end
        bx_vld[N] = 1'b0;
        bx_key[N] = '0;
        bx_val[N] = '0;
    end

    // Pull pass: each cell refills B[k] from A[k] or B[k+1]; the loser stays in A[k].
    always_comb begin
        for (int k = 0; k < N; k++) begin
            if (better(a_vld[k], a_key[k], bx_vld[k+1], bx_key[k+1])) begin
                pb_vld[k] = a_vld[k];
                pb_key[k] = a_key[k];
                pb_val[k] = a_val[k];
                pa_vld[k] = bx_vld[k+1];
                pa_key[k] = bx_key[k+1];
                pa_val[k] = bx_val[k+1];
            end else begin
                pb_vld[k] = bx_vld[k+1];
                pb_key[k] = bx_key[k+1];
                pb_val[k] = bx_val[k+1];
                pa_vld[k] = a_vld[k];
                pa_key[k] = a_key[k];
                pa_val[k] = a_val[k];
            end
        end
    end

    // Insert source: a replace inserts into the already-popped row.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            sa_vld[k] = do_rep ? pa_vld[k] : a_vld[k];
            sa_key[k] = do_rep ? pa_key[k] : a_key[k];
            sa_val[k] = do_rep ? pa_val[k] : a_val[k];
        end
    end

    // Shift A right only up to the first hole so no stored entry falls off the end.
    always_comb begin
        logic run;
        run = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (k == 0) begin
                ia_vld[k] = 1'b1;
                ia_key[k] = i_key;
                ia_val[k] = i_val;
            end else if (run) begin
                ia_vld[k] = sa_vld[k-1];
                ia_key[k] = sa_key[k-1];
                ia_val[k] = sa_val[k-1];
            end else begin
                ia_vld[k] = sa_vld[k];
                ia_key[k] = sa_key[k];
                ia_val[k] = sa_val[k];
            end
            run = run & sa_vld[k];
        end
    end

    // Settle pass: refill after a pop (head hole), otherwise swap A[k] into B[k] if better.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            ta_vld[k] = a_vld[k];
            ta_key[k] = a_key[k];
            ta_val[k] = a_val[k];
            tb_vld[k] = b_vld[k];
            tb_key[k] = b_key[k];
            tb_val[k] = b_val[k];
            if (!b_vld[0]) begin
                ta_vld[k] = pa_vld[k];
                ta_key[k] = pa_key[k];
                ta_val[k] = pa_val[k];
                tb_vld[k] = pb_vld[k];
                tb_key[k] = pb_key[k];
                tb_val[k] = pb_val[k];
            end else if (better(a_vld[k], a_key[k], b_vld[k], b_key[k])) begin
                ta_vld[k] = b_vld[k];
                ta_key[k] = b_key[k];
                ta_val[k] = b_val[k];
                tb_vld[k] = a_vld[k];
                tb_key[k] = a_key[k];
                tb_val[k] = a_val[k];
            end
        end
    end

    // FSM state, occupancy count and drop pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_READY;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (do_flush)                  count_q <= '0;
            else if (do_enq)               count_q <= count_q + CW'(1);
            else if (do_deq)               count_q <= count_q - CW'(1);
            else if (do_rep && empty)      count_q <= count_q + CW'(1);
        end
    end

    // Cell storage: op applied at acceptance, compare-exchange applied in SETTLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < N; k++) begin
                a_vld[k] <= 1'b0;
                a_key[k] <= '0;
                a_val[k] <= '0;
                b_vld[k] <= 1'b0;
                b_key[k] <= '0;
                b_val[k] <= '0;
            end
        end else if (state_q == ST_SETTLE) begin
            for (int k = 0; k < N; k++) begin
                a_vld[k] <= ta_vld[k];
                a_key[k] <= ta_key[k];
                a_val[k] <= ta_val[k];
                b_vld[k] <= tb_vld[k];
                b_key[k] <= tb_key[k];
                b_val[k] <= tb_val[k];
            end
        end else if (do_flush) begin
            for (int k = 0; k < N; k++) begin
                a_vld[k] <= 1'b0;
                b_vld[k] <= 1'b0;
            end
        end else if (do_enq) begin
            for (int k = 0; k < N; k++) begin
                a_vld[k] <= ia_vld[k];
                a_key[k] <= ia_key[k];
                a_val[k] <= ia_val[k];
            end
        end else if (do_deq) begin
            b_vld[0] <= 1'b0;
        end else if (do_rep) begin
            for (int k = 0; k < N; k++) begin
                a_vld[k] <= ia_vld[k];
                a_key[k] <= ia_key[k];
                a_val[k] <= ia_val[k];
                b_vld[k] <= pb_vld[k];
                b_key[k] <= pb_key[k];
                b_val[k] <= pb_val[k];
            end
        end
    end

    assign o_ready = (state_q == ST_READY);
    assign o_full  = full;
    assign o_empty = empty;
    assign o_count = count_q;
    assign o_valid = b_vld[0];
    assign o_key   = b_vld[0] ? b_key[0] : '0;
    assign o_val   = b_vld[0] ? b_val[0] : '0;
    assign o_drop  = drop_q;

endmodule

// File: tb/tb_systolic_array_kv.sv
// Directed bench for systolic_array_kv: a min-queue and a max-queue instance,
// a reference queue model per instance, expected results queued per op.
module tb_systolic_array_kv;

    localparam int QS = 4;
    localparam int KW = 8;
    localparam int VW = 16;
    localparam int CW = $clog2(QS + 1);

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic          m_wrt = 0, m_read = 0, m_flush = 0;
    logic [KW-1:0] m_key = '0;
    logic [VW-1:0] m_val = '0;
    logic          m_ready, m_full, m_empty, m_valid, m_drop;
    logic [CW-1:0] m_count;
    logic [KW-1:0] m_okey;
    logic [VW-1:0] m_oval;

    logic          x_wrt = 0, x_read = 0, x_flush = 0;
    logic [KW-1:0] x_key = '0;
    logic [VW-1:0] x_val = '0;
    logic          x_ready, x_full, x_empty, x_valid, x_drop;
    logic [CW-1:0] x_count;
    logic [KW-1:0] x_okey;
    logic [VW-1:0] x_oval;

    systolic_array_kv #(.QUEUE_SIZE(QS), .KEY_WIDTH(KW), .VAL_WIDTH(VW), .MAX_MODE(0)) u_min (
        .CLK(CLK), .RST(RST), .i_wrt(m_wrt), .i_read(m_read), .i_flush(m_flush),
        .i_key(m_key), .i_val(m_val), .o_ready(m_ready), .o_full(m_full),
        .o_empty(m_empty), .o_count(m_count), .o_valid(m_valid), .o_key(m_okey),
        .o_val(m_oval), .o_drop(m_drop));

    systolic_array_kv #(.QUEUE_SIZE(QS), .KEY_WIDTH(KW), .VAL_WIDTH(VW), .MAX_MODE(1)) u_max (
        .CLK(CLK), .RST(RST), .i_wrt(x_wrt), .i_read(x_read), .i_flush(x_flush),
        .i_key(x_key), .i_val(x_val), .o_ready(x_ready), .o_full(x_full),
        .o_empty(x_empty), .o_count(x_count), .o_valid(x_valid), .o_key(x_okey),
        .o_val(x_oval), .o_drop(x_drop));

    typedef struct {
        logic          vld;
        logic [KW-1:0] key;
        logic [VW-1:0] val;
        int            cnt;
        logic          drop;
    } exp_t;

    exp_t sb[$];
    int   mmod[$];
    int   xmod[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [VW-1:0] pay(input logic [KW-1:0] k);
        return {k, ~k};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Model the op, push the expectation, drive the DUT, then pop and compare.
    task automatic op(input int sel, input logic w, input logic r, input logic f,
                      input logic [KW-1:0] k, input int hold, input string tag);
        int   q[$];
        int   n;
        int   bi;
        exp_t e;
        exp_t g;
        logic drop_seen;
        n = 0;
        while (((sel == 0) ? m_ready : x_ready) !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_ready_wait"}, {31'd0, (sel == 0) ? m_ready : x_ready}, 32'd1);

        q = (sel == 0) ? mmod : xmod;
        e.drop = 1'b0;
        if (f) begin
            q.delete();
        end else if (w && !r) begin
            if (q.size() < QS) q.push_back(int'(k));
            else e.drop = 1'b1;
        end else if (r && !w) begin
            if (q.size() == 0) e.drop = 1'b1;
        end
        if (!f && r && q.size() > 0 && !(e.drop)) begin
            bi = 0;
            for (int i = 1; i < q.size(); i++)
                if ((sel == 0) ? (q[i] < q[bi]) : (q[i] > q[bi])) bi = i;
            q.delete(bi);
            if (w) q.push_back(int'(k));
        end else if (!f && w && r) begin
            q.push_back(int'(k));
        end
        if (sel == 0) mmod = q; else xmod = q;
        e.cnt = q.size();
        e.vld = (q.size() > 0);
        e.key = '0;
        e.val = '0;
        if (q.size() > 0) begin
            bi = 0;
            for (int i = 1; i < q.size(); i++)
                if ((sel == 0) ? (q[i] < q[bi]) : (q[i] > q[bi])) bi = i;
            e.key = KW'(q[bi]);
            e.val = pay(KW'(q[bi]));
        end
        sb.push_back(e);

        if (sel == 0) begin
            m_wrt = w; m_read = r; m_flush = f; m_key = k; m_val = pay(k);
        end else begin
            x_wrt = w; x_read = r; x_flush = f; x_key = k; x_val = pay(k);
        end
        @(negedge CLK);
        drop_seen = (sel == 0) ? m_drop : x_drop;
        if (hold != 0) @(negedge CLK);
        if (sel == 0) begin
            m_wrt = 0; m_read = 0; m_flush = 0;
        end else begin
            x_wrt = 0; x_read = 0; x_flush = 0;
        end
        @(negedge CLK);

        g = sb.pop_front();
        if (sel == 0) begin
            chk({tag, "_drop"},  {31'd0, drop_seen}, {31'd0, g.drop});
            chk({tag, "_drop_after"}, {31'd0, m_drop}, 32'd0);
            chk({tag, "_ready"}, {31'd0, m_ready}, 32'd1);
            chk({tag, "_count"}, {29'd0, m_count}, 32'(g.cnt));
            chk({tag, "_full"},  {31'd0, m_full},  {31'd0, g.cnt == QS});
            chk({tag, "_empty"}, {31'd0, m_empty}, {31'd0, g.cnt == 0});
            chk({tag, "_valid"}, {31'd0, m_valid}, {31'd0, g.vld});
            chk({tag, "_key"},   {24'd0, m_okey},  {24'd0, g.key});
            chk({tag, "_val"},   {16'd0, m_oval},  {16'd0, g.val});
        end else begin
            chk({tag, "_drop"},  {31'd0, drop_seen}, {31'd0, g.drop});
            chk({tag, "_drop_after"}, {31'd0, x_drop}, 32'd0);
            chk({tag, "_ready"}, {31'd0, x_ready}, 32'd1);
            chk({tag, "_count"}, {29'd0, x_count}, 32'(g.cnt));
            chk({tag, "_full"},  {31'd0, x_full},  {31'd0, g.cnt == QS});
            chk({tag, "_empty"}, {31'd0, x_empty}, {31'd0, g.cnt == 0});
            chk({tag, "_valid"}, {31'd0, x_valid}, {31'd0, g.vld});
            chk({tag, "_key"},   {24'd0, x_okey},  {24'd0, g.key});
            chk({tag, "_val"},   {16'd0, x_oval},  {16'd0, g.val});
        end
    endtask

    initial begin
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_ready", {31'd0, m_ready}, 32'd1);
        chk("rst_empty", {31'd0, m_empty}, 32'd1);
        chk("rst_full",  {31'd0, m_full},  32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_drop",  {31'd0, m_drop},  32'd0);
        chk("rst_key",   {24'd0, m_okey},  32'd0);
        chk("rst_count", {29'd0, m_count}, 32'd0);
        chk("rst_x_empty", {31'd0, x_empty}, 32'd1);

        // min mode: fill, overflow, drain, underflow
        op(0, 1, 0, 0, 8'd30, 0, "enq30");
        op(0, 1, 0, 0, 8'd10, 0, "enq10");
        op(0, 1, 0, 0, 8'd20, 0, "enq20");
        op(0, 1, 0, 0, 8'd40, 0, "enq40");
        op(0, 1, 0, 0, 8'd50, 0, "enq_full");
        op(0, 0, 1, 0, 8'd0,  0, "deq1");
        op(0, 0, 1, 0, 8'd0,  0, "deq2");
        op(0, 0, 1, 0, 8'd0,  0, "deq3");
        op(0, 0, 1, 0, 8'd0,  0, "deq4");
        op(0, 0, 1, 0, 8'd0,  0, "deq_empty");

        // replace on a full queue
        op(0, 1, 0, 0, 8'd40, 0, "fill40");
        op(0, 1, 0, 0, 8'd20, 0, "fill20");
        op(0, 1, 0, 0, 8'd10, 0, "fill10");
        op(0, 1, 0, 0, 8'd30, 0, "fill30");
        op(0, 1, 1, 0, 8'd5,  0, "rep5");
        op(0, 1, 1, 0, 8'd50, 0, "rep50");

        // request held through SETTLE counts once; flush beats write
        op(0, 0, 1, 0, 8'd0,  1, "deq_hold");
        op(0, 1, 0, 1, 8'd7,  0, "flush_wrt");
        op(0, 1, 1, 0, 8'd9,  0, "rep_empty");
        op(0, 0, 1, 0, 8'd0,  0, "deq_last");

        // max mode: all-ones keys are ordinary entries
        op(1, 1, 0, 0, 8'hFF, 0, "x_enqFF_a");
        op(1, 1, 0, 0, 8'h00, 0, "x_enq00");
        op(1, 1, 0, 0, 8'hFF, 0, "x_enqFF_b");
        op(1, 0, 1, 0, 8'd0,  0, "x_deq1");
        op(1, 0, 1, 0, 8'd0,  0, "x_deq2");
        op(1, 0, 1, 0, 8'd0,  0, "x_deq3");

        // reset in the middle of a SETTLE with two entries
        op(0, 1, 0, 0, 8'd60, 0, "pre_rst_a");
        op(0, 1, 0, 0, 8'd70, 0, "pre_rst_b");
        m_wrt = 1; m_key = 8'd80; m_val = pay(8'd80);
        @(negedge CLK);
        m_wrt = 0;
        chk("mid_settle_ready", {31'd0, m_ready}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        mmod.delete();
        chk("rst_settle_empty", {31'd0, m_empty}, 32'd1);
        chk("rst_settle_ready", {31'd0, m_ready}, 32'd1);
        chk("rst_settle_drop",  {31'd0, m_drop},  32'd0);
        chk("rst_settle_count", {29'd0, m_count}, 32'd0);
        chk("rst_settle_valid", {31'd0, m_valid}, 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
